output_drain_seq: RTL

Read-back sequencer downstream of the accelerator top. After a layer finishes, it steps the filter-select mux and the BRAM read address across every (filter, word) pair. It captures each 16-bit filter output and streams it on a valid/ready interface, tagged with filter index and end-of-filter/end-of-layer flags. A credit-based skid FIFO absorbs the fixed read latency, so backpressure never loses data.

---
 rtl/sparhixcel_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/output_drain_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/sparhixcel_pkg.sv
// Shared types and sizes for the accelerator read-back path.
// Pure declarations; no timing or flow control.
package sparhixcel_pkg;

    localparam int N_FILTERS       = 30;
    localparam int FSEL_WIDTH      = $clog2(N_FILTERS);
    localparam int BRAM_ADDR_WIDTH = 11;
    localparam int DATA_WIDTH      = 16;

    typedef struct packed {
        logic [FSEL_WIDTH-1:0] filter;
        logic                  eof;
        logic                  last;
    } drain_tag_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } drain_state_t;

    function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] x, input logic en);
        return (en && x[DATA_WIDTH-1]) ? '0 : x;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a write is readable on rd_data one cycle later.
// Writes while full are dropped and flagged by assertion; reads while empty are ignored.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             full, do_wr, do_rd;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= bump(wr_ptr);
            if (do_rd) rd_ptr <= bump(rd_ptr);
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr_en && full));

endmodule

// File: rtl/output_drain_seq.sv
// Walks every (filter, word) read after a layer and streams results; first beat READ_LATENCY+2 cycles after start.
// Reads are issued only against free FIFO credit, so m_ready_i backpressure never drops a beat.
module output_drain_seq
    import sparhixcel_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [FSEL_WIDTH-1:0]      n_filters_i,
    input  logic [BRAM_ADDR_WIDTH-1:0] n_words_i,
    input  logic                       relu_en_i,
    output logic [FSEL_WIDTH-1:0]      sel_mux_final_o,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr_o,
    output logic                       issue_o,
    input  logic [DATA_WIDTH-1:0]      data_i,
    output logic [DATA_WIDTH-1:0]      m_data_o,
    output logic [FSEL_WIDTH-1:0]      m_filter_o,
    output logic                       m_eof_o,
    output logic                       m_last_o,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic                       busy_o,
    output logic                       done_o
);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int TAG_W = $bits(drain_tag_t);
    localparam int ENT_W = DATA_WIDTH + TAG_W;

    drain_state_t                  state_q, state_d;
    logic [FSEL_WIDTH-1:0]         f_q, nf_q;
    logic [BRAM_ADDR_WIDTH-1:0]    a_q, nw_q;
    logic                          relu_q, skip_q;
    logic [CW-1:0]                 inflight_q, fifo_count;
    logic [READ_LATENCY-1:0]       sr_vld;
    drain_tag_t [READ_LATENCY-1:0] sr_tag;
    drain_tag_t                    issue_tag, head_tag;
    logic [DATA_WIDTH-1:0]         head_dat;
    logic [ENT_W-1:0]              head_ent;
    logic                          credits_ok, issue, a_wrap, fifo_empty, valid, pop;

    assign credits_ok = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
    assign issue      = (state_q == ST_RUN) && credits_ok;
    assign a_wrap     = (a_q == nw_q - 1'b1);
    assign valid      = !fifo_empty;
    assign pop        = valid && m_ready_i;
    assign {head_dat, head_tag} = head_ent;

    always_comb begin
        issue_tag        = '0;
        issue_tag.filter = f_q;
        issue_tag.eof    = a_wrap;
        issue_tag.last   = a_wrap && (f_q == nf_q - 1'b1);
    end

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_en   (sr_vld[READ_LATENCY-1]),
        .wr_data ({relu(data_i, relu_q), sr_tag[READ_LATENCY-1]}),
        .rd_en   (pop),
        .rd_data (head_ent),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // An empty drain takes the FLUSH hop so busy/done timing matches a normal drain's tail.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_FLUSH;
            ST_RUN:   if (issue && issue_tag.last) state_d = ST_FLUSH;
            ST_FLUSH: if (skip_q || (pop && head_tag.last)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (state_q == ST_IDLE && start_i && n_filters_i != '0 && n_words_i != '0)
            state_d = ST_RUN;
    end

    always_comb begin
        sel_mux_final_o = '0;
        bram_addr_o     = '0;
        if (state_q == ST_RUN) begin
            sel_mux_final_o = f_q;
            bram_addr_o     = a_q;
        end
        issue_o    = issue;
        m_valid_o  = valid;
        m_data_o   = valid ? head_dat : '0;
        m_filter_o = valid ? head_tag.filter : '0;
        m_eof_o    = valid && head_tag.eof;
        m_last_o   = valid && head_tag.last;
        busy_o     = (state_q != ST_IDLE);
        done_o     = (state_q == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            f_q        <= '0;
            a_q        <= '0;
            nf_q       <= '0;
            nw_q       <= '0;
            relu_q     <= 1'b0;
            skip_q     <= 1'b0;
            inflight_q <= '0;
            sr_vld     <= '0;
            sr_tag     <= '0;
        end else begin
            if (state_q == ST_IDLE && start_i) begin
                nf_q   <= n_filters_i;
                nw_q   <= n_words_i;
                relu_q <= relu_en_i;
                skip_q <= (n_filters_i == '0) || (n_words_i == '0);
                f_q    <= '0;
                a_q    <= '0;
            end else if (issue) begin
                if (a_wrap) begin
                    a_q <= '0;
                    f_q <= f_q + 1'b1;
                end else begin
                    a_q <= a_q + 1'b1;
                end
            end

            case ({issue, sr_vld[READ_LATENCY-1]})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase

            sr_vld[0] <= issue;
            sr_tag[0] <= issue_tag;
            for (int i = 1; i < READ_LATENCY; i++) begin
                sr_vld[i] <= sr_vld[i-1];
                sr_tag[i] <= sr_tag[i-1];
            end
        end
    end

endmodule
